// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing beside the decoder: stage enables, IF/ID flush, ID/MEM-WB bubbles,
// operand forwarding selects, data-memory wait FSM with timeout and a stall-cycle counter.
module hazard_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [3:0]       id_rn_i,
    input  logic [3:0]       id_rm_i,
    input  logic             id_use_rn_i,
    input  logic             id_use_rm_i,
    input  logic             id_b_taken_i,
    input  logic [3:0]       ex_rd_i,
    input  logic [3:0]       mem_rd_i,
    input  logic [3:0]       wb_rd_i,
    input  logic             ex_rf_enable_i,
    input  logic             mem_rf_enable_i,
    input  logic             wb_rf_enable_i,
    input  logic             ex_load_inst_i,
    input  logic             mem_m_enable_i,
    input  logic             mem_ready_i,
    output logic             pc_enable_o,
    output logic             ifid_enable_o,
    output logic             idex_enable_o,
    output logic             exmem_enable_o,
    output logic             ifid_flush_o,
    output logic             id_bubble_o,
    output logic             memwb_bubble_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {StRun, StMemWait, StMemErr} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             freeze;
    logic             load_use;
    logic [1:0]       fwd_a, fwd_b;

    // r15 is the PC and never comes from the bypass network; a load in EX has no result yet.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,
        input logic       used,
        input logic [3:0] ex_rd,
        input logic       ex_ok,
        input logic [3:0] mem_rd,
        input logic       mem_ok,
        input logic [3:0] wb_rd,
        input logic       wb_ok
    );
        if (!used || src == 4'hF)      return 2'b00;
        else if (ex_ok && ex_rd == src)   return 2'b01;
        else if (mem_ok && mem_rd == src) return 2'b10;
        else if (wb_ok && wb_rd == src)   return 2'b11;
        else                              return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(id_rn_i, id_use_rn_i, ex_rd_i, ex_rf_enable_i && !ex_load_inst_i,
                           mem_rd_i, mem_rf_enable_i, wb_rd_i, wb_rf_enable_i);
    assign fwd_b = fwd_sel(id_rm_i, id_use_rm_i, ex_rd_i, ex_rf_enable_i && !ex_load_inst_i,
                           mem_rd_i, mem_rf_enable_i, wb_rd_i, wb_rf_enable_i);

    assign load_use = ex_load_inst_i && ex_rf_enable_i &&
                      ((id_use_rn_i && id_rn_i == ex_rd_i) || (id_use_rm_i && id_rm_i == ex_rd_i));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        freeze  = 1'b0;
        case (state_q)
            StRun: begin
                if (mem_m_enable_i && !mem_ready_i) begin
                    freeze  = 1'b1;
                    state_d = StMemWait;
                    wait_d  = WaitW'(1);
                end
            end
            StMemWait: begin
                if (mem_ready_i) begin
                    state_d = StRun;
                    wait_d  = '0;
                end else if (wait_q == WaitMax) begin
                    freeze  = 1'b1;
                    state_d = StMemErr;
                end else begin
                    freeze  = 1'b1;
                    wait_d  = wait_q + 1'b1;
                end
            end
            StMemErr: freeze = 1'b1;
            default:  state_d = StRun;
        endcase
    end

    always_comb begin
        pc_enable_o    = 1'b1;
        ifid_enable_o  = 1'b1;
        idex_enable_o  = 1'b1;
        exmem_enable_o = 1'b1;
        ifid_flush_o   = 1'b0;
        id_bubble_o    = 1'b0;
        memwb_bubble_o = 1'b0;
        fwd_a_o        = fwd_a;
        fwd_b_o        = fwd_b;
        mem_err_o      = (state_q == StMemErr);
        if (reset_i) begin
            pc_enable_o    = 1'b0;
            ifid_enable_o  = 1'b0;
            idex_enable_o  = 1'b0;
            exmem_enable_o = 1'b0;
            ifid_flush_o   = 1'b1;
            id_bubble_o    = 1'b1;
            memwb_bubble_o = 1'b1;
            fwd_a_o        = 2'b00;
            fwd_b_o        = 2'b00;
            mem_err_o      = 1'b0;
        end else if (freeze) begin
            pc_enable_o    = 1'b0;
            ifid_enable_o  = 1'b0;
            idex_enable_o  = 1'b0;
            exmem_enable_o = 1'b0;
            memwb_bubble_o = 1'b1;
        end else if (load_use) begin
            pc_enable_o   = 1'b0;
            ifid_enable_o = 1'b0;
            id_bubble_o   = 1'b1;
        end else if (id_b_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    assign stall_d     = (!pc_enable_o && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    assign stall_cnt_o = stall_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StRun;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: hand-computed control vectors per scenario.
module tb_hazard_stall_controller;

    localparam int unsigned TO  = 5;
    localparam int unsigned CW  = 4;

    // {pc, ifid, idex, exmem, flush, id_bubble, memwb_bubble}
    localparam logic [6:0] CTL_RESET   = 7'b0000_111;
    localparam logic [6:0] CTL_RUN     = 7'b1111_000;
    localparam logic [6:0] CTL_FREEZE  = 7'b0000_001;
    localparam logic [6:0] CTL_LOADUSE = 7'b0011_010;
    localparam logic [6:0] CTL_BRANCH  = 7'b1111_100;

    logic          clk, reset;
    logic [3:0]    id_rn, id_rm, ex_rd, mem_rd, wb_rd;
    logic          id_use_rn, id_use_rm, id_b_taken;
    logic          ex_rf, mem_rf, wb_rf, ex_load, mem_m, mem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, ifid_flush, id_bubble, memwb_bubble;
    logic [1:0]    fwd_a, fwd_b;
    logic          mem_err;
    logic [CW-1:0] stall_cnt;
    logic [6:0]    ctl;

    int errors = 0;
    int checks = 0;

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, id_bubble, memwb_bubble};

    hazard_stall_controller #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .id_rn_i        (id_rn),
        .id_rm_i        (id_rm),
        .id_use_rn_i    (id_use_rn),
        .id_use_rm_i    (id_use_rm),
        .id_b_taken_i   (id_b_taken),
        .ex_rd_i        (ex_rd),
        .mem_rd_i       (mem_rd),
        .wb_rd_i        (wb_rd),
        .ex_rf_enable_i (ex_rf),
        .mem_rf_enable_i(mem_rf),
        .wb_rf_enable_i (wb_rf),
        .ex_load_inst_i (ex_load),
        .mem_m_enable_i (mem_m),
        .mem_ready_i    (mem_ready),
        .pc_enable_o    (pc_en),
        .ifid_enable_o  (ifid_en),
        .idex_enable_o  (idex_en),
        .exmem_enable_o (exmem_en),
        .ifid_flush_o   (ifid_flush),
        .id_bubble_o    (id_bubble),
        .memwb_bubble_o (memwb_bubble),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b),
        .mem_err_o      (mem_err),
        .stall_cnt_o    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle;
        id_rn = 4'd0; id_rm = 4'd0; id_use_rn = 1'b0; id_use_rm = 1'b0; id_b_taken = 1'b0;
        ex_rd = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0;
        ex_rf = 1'b0; mem_rf = 1'b0; wb_rf = 1'b0; ex_load = 1'b0;
        mem_m = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        idle();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset;
        idle();
        id_rn = 4'd2; id_use_rn = 1'b1; ex_rd = 4'd2; ex_rf = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_RESET) begin
            errors++; $display("FAIL reset_ctl: got %b exp %b", ctl, CTL_RESET);
        end
        checks++;
        if (fwd_a !== 2'b00) begin
            errors++; $display("FAIL reset_fwd_a: got %b exp 00", fwd_a);
        end
        step(); step();
        checks++;
        if (stall_cnt !== 4'd0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL reset_regs: got stall=%0d err=%b exp 0 0", stall_cnt, mem_err);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_RUN || fwd_a !== 2'b01) begin
            errors++; $display("FAIL reset_release: got ctl=%b fwd_a=%b exp %b 01", ctl, fwd_a, CTL_RUN);
        end
        step();
    endtask

    task automatic test_load_use;
        do_reset();
        ex_load = 1'b1; ex_rf = 1'b1; ex_rd = 4'd1;
        id_rn = 4'd1; id_use_rn = 1'b1; id_rm = 4'd3; id_use_rm = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_LOADUSE || fwd_a !== 2'b00) begin
            errors++; $display("FAIL load_use_rn: got ctl=%b fwd_a=%b exp %b 00", ctl, fwd_a, CTL_LOADUSE);
        end
        step();
        ex_load = 1'b0; ex_rf = 1'b0; mem_rf = 1'b1; mem_rd = 4'd1;
        #1;
        checks++;
        if (ctl !== CTL_RUN || fwd_a !== 2'b10 || stall_cnt !== 4'd1) begin
            errors++; $display("FAIL load_use_after: got ctl=%b fwd_a=%b stall=%0d exp %b 10 1",
                               ctl, fwd_a, stall_cnt, CTL_RUN);
        end
        step();
        mem_rf = 1'b0; ex_load = 1'b1; ex_rf = 1'b1; ex_rd = 4'd3;
        #1;
        checks++;
        if (ctl !== CTL_LOADUSE) begin
            errors++; $display("FAIL load_use_rm: got %b exp %b", ctl, CTL_LOADUSE);
        end
        step();
        id_use_rm = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_RUN || stall_cnt !== 4'd2) begin
            errors++; $display("FAIL load_use_unused: got ctl=%b stall=%0d exp %b 2", ctl, stall_cnt, CTL_RUN);
        end
        step();
    endtask

    task automatic test_forwarding;
        do_reset();
        id_rn = 4'd4; id_use_rn = 1'b1;
        ex_rd = 4'd4; ex_rf = 1'b1; mem_rd = 4'd4; mem_rf = 1'b1;
        #1;
        checks++;
        if (fwd_a !== 2'b01) begin
            errors++; $display("FAIL fwd_ex_priority: got %b exp 01", fwd_a);
        end
        ex_rf = 1'b0;
        #1;
        checks++;
        if (fwd_a !== 2'b10) begin
            errors++; $display("FAIL fwd_mem: got %b exp 10", fwd_a);
        end
        mem_rf = 1'b0; wb_rd = 4'd4; wb_rf = 1'b1;
        #1;
        checks++;
        if (fwd_a !== 2'b11) begin
            errors++; $display("FAIL fwd_wb: got %b exp 11", fwd_a);
        end
        id_rn = 4'hF; ex_rd = 4'hF; ex_rf = 1'b1; mem_rd = 4'hF; mem_rf = 1'b1; wb_rd = 4'hF;
        #1;
        checks++;
        if (fwd_a !== 2'b00) begin
            errors++; $display("FAIL fwd_r15: got %b exp 00", fwd_a);
        end
        id_rn = 4'd6; ex_rd = 4'd6; id_use_rn = 1'b0;
        #1;
        checks++;
        if (fwd_a !== 2'b00) begin
            errors++; $display("FAIL fwd_unused: got %b exp 00", fwd_a);
        end
        ex_rf = 1'b0; id_rm = 4'd5; id_use_rm = 1'b1; mem_rd = 4'd5; wb_rd = 4'd5;
        #1;
        checks++;
        if (fwd_b !== 2'b10 || ctl !== CTL_RUN) begin
            errors++; $display("FAIL fwd_b_mem: got fwd_b=%b ctl=%b exp 10 %b", fwd_b, ctl, CTL_RUN);
        end
        step();
    endtask

    task automatic test_branch;
        do_reset();
        id_b_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_BRANCH) begin
            errors++; $display("FAIL branch_flush: got %b exp %b", ctl, CTL_BRANCH);
        end
        step();
        id_b_taken = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_RUN || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL branch_after: got ctl=%b stall=%0d exp %b 0", ctl, stall_cnt, CTL_RUN);
        end
        step();
        id_b_taken = 1'b1; ex_load = 1'b1; ex_rf = 1'b1; ex_rd = 4'd7; id_rn = 4'd7; id_use_rn = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_LOADUSE) begin
            errors++; $display("FAIL branch_vs_load_use: got %b exp %b", ctl, CTL_LOADUSE);
        end
        step();
        ex_load = 1'b0; ex_rf = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_BRANCH || stall_cnt !== 4'd1) begin
            errors++; $display("FAIL branch_retry: got ctl=%b stall=%0d exp %b 1", ctl, stall_cnt, CTL_BRANCH);
        end
        step();
    endtask

    task automatic test_mem_wait;
        do_reset();
        mem_m = 1'b1; mem_ready = 1'b0;
        ex_load = 1'b1; ex_rf = 1'b1; ex_rd = 4'd2; id_rn = 4'd2; id_use_rn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== CTL_FREEZE) begin
                errors++; $display("FAIL mem_wait_freeze%0d: got %b exp %b", i, ctl, CTL_FREEZE);
            end
            step();
            ex_load = 1'b0; ex_rf = 1'b0;
        end
        mem_ready = 1'b1; id_b_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_BRANCH) begin
            errors++; $display("FAIL mem_wait_release: got %b exp %b", ctl, CTL_BRANCH);
        end
        step();
        idle();
        #1;
        checks++;
        if (ctl !== CTL_RUN || stall_cnt !== 4'd3 || mem_err !== 1'b0) begin
            errors++; $display("FAIL mem_wait_after: got ctl=%b stall=%0d err=%b exp %b 3 0",
                               ctl, stall_cnt, mem_err, CTL_RUN);
        end
        step();
    endtask

    task automatic test_ready_on_timeout;
        do_reset();
        mem_m = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < TO; i++) step();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++; $display("FAIL timeout_ready_wins: got %b exp %b", ctl, CTL_RUN);
        end
        step();
        idle();
        #1;
        checks++;
        if (mem_err !== 1'b0 || ctl !== CTL_RUN || stall_cnt !== CW'(TO)) begin
            errors++; $display("FAIL timeout_ready_after: got err=%b ctl=%b stall=%0d exp 0 %b %0d",
                               mem_err, ctl, stall_cnt, CTL_RUN, TO);
        end
        step();
    endtask

    task automatic test_timeout;
        bit early_err = 1'b0;
        do_reset();
        mem_m = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i <= TO; i++) begin
            #1;
            if (mem_err !== 1'b0) early_err = 1'b1;
            step();
        end
        checks++;
        if (early_err) begin
            errors++; $display("FAIL timeout_early: got err=1 before %0d cycles exp 0", TO + 1);
        end
        mem_m = 1'b0; mem_ready = 1'b1;
        #1;
        checks++;
        if (mem_err !== 1'b1 || ctl !== CTL_FREEZE) begin
            errors++; $display("FAIL timeout_err: got err=%b ctl=%b exp 1 %b", mem_err, ctl, CTL_FREEZE);
        end
        for (int i = 0; i < 14; i++) step();
        checks++;
        if (mem_err !== 1'b1 || ctl !== CTL_FREEZE || stall_cnt !== 4'hF) begin
            errors++; $display("FAIL timeout_sticky_sat: got err=%b ctl=%b stall=%0d exp 1 %b 15",
                               mem_err, ctl, stall_cnt, CTL_FREEZE);
        end
        do_reset();
        checks++;
        if (mem_err !== 1'b0 || ctl !== CTL_RUN || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL timeout_cleared: got err=%b ctl=%b stall=%0d exp 0 %b 0",
                               mem_err, ctl, stall_cnt, CTL_RUN);
        end
    endtask

    task automatic test_reset_mid_wait;
        do_reset();
        mem_m = 1'b1; mem_ready = 1'b0;
        step(); step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_RESET || stall_cnt !== 4'd0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL reset_mid_wait: got ctl=%b stall=%0d err=%b exp %b 0 0",
                               ctl, stall_cnt, mem_err, CTL_RESET);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_m = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++; $display("FAIL reset_mid_wait_state: got %b exp %b", ctl, CTL_RUN);
        end
        step();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_mem_wait();
        test_ready_on_timeout();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
